// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-pass controller wrapped around a purely combinational 64-bit barrel
// shifter. It widens the shifter's native 0..31 range to 0..63 by issuing
// up to three passes of at most 31 positions each, holding the operand in a
// work register between passes and exposing a start/busy/done handshake.
//
// Optional feature: define SHIFT_ZERO_FLAG_EN to add the o_zero output,
// which flags an all-zero final result and is registered alongside o_done.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; shifter driven with samt=0, sel=0
// SHIFT | one pass per cycle; work <- shifter result, rem <- rem - samt
module shift_sequencer (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [3:0]  i_op,
   input  logic [5:0]  i_amt,
   input  logic [63:0] i_d_in,
   output logic        o_busy,
   output logic        o_done,
   output logic [63:0] o_result,
   output logic [63:0] o_S_mux_out,
   output logic [4:0]  o_samt,
   output logic [3:0]  o_B_Sel,
`ifdef SHIFT_ZERO_FLAG_EN
   output logic        o_zero,
`endif
   input  logic [63:0] i_barrel_mux_out
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [63:0] r_work;
   logic [3:0]  r_op;
   logic [5:0]  r_rem;
   logic        r_done;

   logic        w_busy;
   logic        w_accept;
   logic        w_last;
   logic [4:0]  w_samt;
   logic [3:0]  w_sel;
   logic [3:0]  w_op_legal;

   // Codes 10..15 are not shifter operations; they run as pass-through.
   assign w_op_legal = (i_op > 4'd9) ? 4'd0 : i_op;

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and per-pass shifter controls.
   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b0;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      w_samt       = 5'd0;
      w_sel        = 4'd0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_accept     = 1'b1;
               w_next_state = SHIFT;
            end
         end
         SHIFT: begin
            w_busy = 1'b1;
            w_sel  = r_op;
            if (r_rem > 6'd31) begin
               w_samt = 5'd31;
            end else begin
               w_samt       = r_rem[4:0];
               w_last       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Operand/result work register, remaining amount and done pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_work <= 64'd0;
         r_op   <= 4'd0;
         r_rem  <= 6'd0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_work <= i_d_in;
            r_op   <= w_op_legal;
            r_rem  <= i_amt;
         end else if (w_busy) begin
            r_work <= i_barrel_mux_out;
            r_rem  <= r_rem - {1'b0, w_samt};
         end
      end
   end

`ifdef SHIFT_ZERO_FLAG_EN
   logic r_zero;

   // Zero flag lands with done and holds until the next accepted start.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_zero <= 1'b0;
      end else if (w_accept) begin
         r_zero <= 1'b0;
      end else if (w_last) begin
         r_zero <= (i_barrel_mux_out == 64'd0);
      end
   end

   assign o_zero = r_zero;
`endif

   assign o_busy      = w_busy;
   assign o_done      = r_done;
   assign o_result    = r_work;
   assign o_S_mux_out = r_work;
   assign o_samt      = w_samt;
   assign o_B_Sel     = w_sel;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer. Supplies a behavioural barrel shifter
// on the downstream side and checks per-pass controls, results and timing.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [5:0]  amt;
   logic [63:0] d_in;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic [63:0] s_mux_out;
   logic [4:0]  samt;
   logic [3:0]  b_sel;
   logic [63:0] barrel_out;
`ifdef SHIFT_ZERO_FLAG_EN
   logic        zero;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_sequencer dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .i_op             (op),
      .i_amt            (amt),
      .i_d_in           (d_in),
      .o_busy           (busy),
      .o_done           (done),
      .o_result         (result),
      .o_S_mux_out      (s_mux_out),
      .o_samt           (samt),
      .o_B_Sel          (b_sel),
`ifdef SHIFT_ZERO_FLAG_EN
      .o_zero           (zero),
`endif
      .i_barrel_mux_out (barrel_out)
   );

   // Behavioural barrel shifter: one pass of 0..31 positions.
   always_comb begin
      logic [63:0] ones;
      ones = '1;
      case (b_sel)
         4'd1, 4'd3: barrel_out = s_mux_out << samt;
         4'd2:       barrel_out = s_mux_out >> samt;
         4'd4:       barrel_out = $unsigned($signed(s_mux_out) >>> samt);
         4'd5:       barrel_out = (s_mux_out << samt) | (s_mux_out >> (7'd64 - {2'b0, samt}));
         4'd6:       barrel_out = (s_mux_out >> samt) | (s_mux_out << (7'd64 - {2'b0, samt}));
         4'd7, 4'd9: barrel_out = (s_mux_out << samt) | ~(ones << samt);
         4'd8:       barrel_out = (s_mux_out >> samt) | ~(ones >> samt);
         default:    barrel_out = s_mux_out;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [63:0] d;
      logic [3:0]  op;
      logic [5:0]  amt;
      logic [63:0] exp;
      int          passes;
      logic        exp_zero;
   } vec_t;

   // Drives one operation from the idle state and checks every pass.
   task automatic run_op(input vec_t v, input string tag);
      int          npass;
      int          rem;
      logic [63:0] exp_samt;
      logic [3:0]  exp_sel;
      d_in  = v.d;
      op    = v.op;
      amt   = v.amt;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      d_in  = ~v.d;
      op    = 4'd6;
      amt   = 6'd17;
      rem     = int'(v.amt);
      exp_sel = (v.op > 4'd9) ? 4'd0 : v.op;
      npass   = 0;
      while (!done && npass < 6) begin
         exp_samt = (rem > 31) ? 64'd31 : 64'(rem);
         chk({tag, " busy"}, {63'd0, busy}, 64'd1);
         chk({tag, " samt"}, {59'd0, samt}, exp_samt);
         chk({tag, " sel"}, {60'd0, b_sel}, {60'd0, exp_sel});
         rem = rem - int'(exp_samt);
         npass++;
         @(negedge clk);
      end
      chk({tag, " passes"}, 64'(npass), 64'(v.passes));
      chk({tag, " done"}, {63'd0, done}, 64'd1);
      chk({tag, " idle busy"}, {63'd0, busy}, 64'd0);
      chk({tag, " idle samt/sel"}, {55'd0, samt, b_sel}, 64'd0);
      chk({tag, " result"}, result, v.exp);
`ifdef SHIFT_ZERO_FLAG_EN
      chk({tag, " zero"}, {63'd0, zero}, {63'd0, v.exp_zero});
`endif
      @(negedge clk);
      chk({tag, " done falls"}, {63'd0, done}, 64'd0);
      chk({tag, " result held"}, result, v.exp);
   endtask

   vec_t vt[14];

   initial begin
      int cyc;
      vt[0]  = '{64'h1, 4'd1, 6'd63, 64'h8000_0000_0000_0000, 3, 1'b0};
      vt[1]  = '{64'h8000_0000_0000_0001, 4'd5, 6'd40, 64'h0000_0180_0000_0000, 2, 1'b0};
      vt[2]  = '{64'h8000_0000_0000_0000, 4'd4, 6'd32, 64'hFFFF_FFFF_8000_0000, 2, 1'b0};
      vt[3]  = '{64'h8000_0000_0000_0000, 4'd12, 6'd5, 64'h8000_0000_0000_0000, 1, 1'b0};
      vt[4]  = '{64'hDEAD_BEEF_0000_0000, 4'd2, 6'd0, 64'hDEAD_BEEF_0000_0000, 1, 1'b0};
      vt[5]  = '{64'h1, 4'd2, 6'd63, 64'h0, 3, 1'b1};
      vt[6]  = '{64'h1, 4'd6, 6'd1, 64'h8000_0000_0000_0000, 1, 1'b0};
      vt[7]  = '{64'h0, 4'd7, 6'd4, 64'hF, 1, 1'b0};
      vt[8]  = '{64'h0, 4'd8, 6'd32, 64'hFFFF_FFFF_0000_0000, 2, 1'b0};
      vt[9]  = '{64'h1234, 4'd0, 6'd31, 64'h1234, 1, 1'b0};
      vt[10] = '{64'h1, 4'd1, 6'd31, 64'h8000_0000, 1, 1'b0};
      vt[11] = '{64'h1, 4'd1, 6'd32, 64'h1_0000_0000, 2, 1'b0};
      vt[12] = '{64'h0, 4'd9, 6'd62, 64'h3FFF_FFFF_FFFF_FFFF, 2, 1'b0};
      vt[13] = '{64'hFF, 4'd3, 6'd8, 64'hFF00, 1, 1'b0};

      reset = 1'b1;
      start = 1'b0;
      op    = 4'd0;
      amt   = 6'd0;
      d_in  = 64'd0;
      #12;
      chk("reset busy/done", {62'd0, busy, done}, 64'd0);
      chk("reset result", result, 64'd0);
      chk("reset smux", s_mux_out, 64'd0);
      chk("reset samt/sel", {55'd0, samt, b_sel}, 64'd0);
`ifdef SHIFT_ZERO_FLAG_EN
      chk("reset zero", {63'd0, zero}, 64'd0);
`endif
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_op(vt[i], $sformatf("vec%0d", i));
      end

      // Start during pass 2 of a 3-pass op is ignored.
      d_in = 64'h1; op = 4'd1; amt = 6'd63; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      d_in = 64'hFFFF_0000_FFFF_0000; op = 4'd0; amt = 6'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign pass3 samt", {59'd0, samt}, 64'd1);
      @(negedge clk);
      chk("ign done", {63'd0, done}, 64'd1);
      chk("ign result", result, 64'h8000_0000_0000_0000);
      @(negedge clk);
      chk("ign no restart", {63'd0, busy}, 64'd0);

      // Start held high: back-to-back ops every N+1 cycles.
      d_in = 64'h1; op = 4'd1; amt = 6'd32; start = 1'b1;
      cyc = 0;
      while (!done && cyc < 10) begin @(negedge clk); cyc++; end
      chk("b2b first done", {63'd0, done}, 64'd1);
      chk("b2b first result", result, 64'h1_0000_0000);
      cyc = 0;
      @(negedge clk);
      cyc++;
      chk("b2b restart busy", {63'd0, busy}, 64'd1);
      while (!done && cyc < 10) begin @(negedge clk); cyc++; end
      start = 1'b0;
      chk("b2b period", 64'(cyc), 64'd3);
      @(negedge clk);

      // Reset during pass 2 aborts asynchronously; next op completes.
      d_in = 64'h1; op = 4'd1; amt = 6'd63; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst abort busy/done", {62'd0, busy, done}, 64'd0);
      chk("rst abort result", result, 64'd0);
      @(negedge clk);
      chk("rst no done", {63'd0, done}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      run_op(vt[13], "post-reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-pass controller that sits directly around the 64-bit barrel shifter.
- Upstream role: supplies the shifter's operand, shift amount and select.
- Downstream role: captures the shifter's result back into its work register.
- Purpose: extends the shifter's native 0–31 shift range to 0–63 by issuing up to three passes of at most 31 each, under a start/done handshake.
- The shifter itself stays purely combinational. All sequencing, operand holding and result holding live here.

## Interface
Parameters: none (data width fixed at 64, select width fixed at 4).
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- op  in  4  operation code:
  - 0 pass, 1 shl, 2 shr, 3 ashl, 4 ashr, 5 rol, 6 ror
  - 7 shl-fill-1, 8 shr-fill-1, 9 ashl-fill-1
- amt  in  6  total shift amount, 0..63
- d_in  in  64  operand
- busy  out  1  high while passes are in progress
- done  out  1  one-cycle pulse; result is valid from this cycle on
- result  out  64  final value; held until the next accepted start
- S_mux_out  out  64  operand to the shifter (always the work register)
- samt  out  5  per-pass amount to the shifter
- B_Sel  out  4  select to the shifter
- barrel_mux_out  in  64  combinational result from the shifter

## Operation
States:
- IDLE: busy=0. Drives samt=0, B_Sel=0.
  - start=1 at a clock edge: work←d_in, op_r←op (codes 10–15 stored as 0), rem←amt; go to SHIFT.
- SHIFT: busy=1. Drives samt = min(rem,31) and B_Sel = op_r.
  - Each edge: work←barrel_mux_out, rem←rem−samt.
  - If rem≤31 before the edge: go to IDLE and set done←1 for the next cycle.
- Pass count is max(1, ceil(amt/31)):
  - amt 0 → 1 pass with samt=0
  - 1–31 → 1 pass
  - 32–62 → 2 passes
  - 63 → 3 passes (31, 31, 1)
- All ten operations compose under repeated passes, so the final value equals a single shift by amt.
- Illegal op codes 10–15 execute as pass-through, consuming the same number of passes.
- result is the work register. It is stable in IDLE and changes during SHIFT.
- start while busy=1 is ignored; no queueing.
- start in the done cycle (state IDLE) is accepted. done still falls at the next edge.
- d_in, op and amt are sampled only at the accepting edge. Later changes have no effect on an operation in progress.

## Timing
- Reset values: busy=0, done=0, result=0, S_mux_out=0, samt=0, B_Sel=0. State is IDLE, rem=0.
- Reset asserted mid-operation aborts immediately to the reset values. No done pulse is produced.
- Latency: start accepted at edge T0. Pass k occupies the cycle after edge T0+k−1. done=1 in the cycle after edge T0+N, where N is the pass count.
- Cycles from start to done: 1, 2 or 3.
- The shifter path is combinational within one cycle: from S_mux_out/samt/B_Sel through barrel_mux_out to the work register.
- Back-to-back operations: one operation every N+1 cycles at minimum when start is held high.

## Configuration
- SHIFT_ZERO_FLAG_EN defined:
  - adds output zero (1 bit, reset 0).
  - zero is registered alongside done: it equals (final work value == 0) and holds until the next accepted start.
- SHIFT_ZERO_FLAG_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- d_in=64'h1, op=1, amt=63 → samt sequence 31, 31, 1; result=64'h8000_0000_0000_0000; done 3 cycles after start.
- d_in=64'h8000_0000_0000_0001, op=5, amt=40 → 2 passes (31, 9); result=64'h0000_0180_0000_0000.
- d_in=64'h8000_0000_0000_0000, op=4, amt=32 → result=64'hFFFF_FFFF_8000_0000. Then op=12, amt=5 on the same d_in → result=d_in after 1 pass.
- d_in=64'hDEAD_BEEF_0000_0000, op=2, amt=0 → 1 pass, result=d_in; zero=0 when SHIFT_ZERO_FLAG_EN is defined. Then op=2, amt=63 on d_in=64'h1 → result=0, zero=1.
- start pulsed again during pass 2 of a 3-pass operation with different d_in → ignored; original result and timing unchanged.
- reset asserted during pass 2 → busy, done and result go to 0 asynchronously. A new start after reset release completes normally.
